// File: rtl/lsu_mem_responder.sv
// ----------------------------------------------------------------------------
// lsu_mem_responder
//
// Purpose:
//   Simple data memory that acts as the target of the load/store unit's
//   memory port. It holds a doubleword-addressed array of 2**DEPTH_BITS
//   64-bit words. Reads return through a fixed READ_LATENCY-deep pipeline.
//   Writes commit in a single cycle. Free-running request counters expose
//   how many reads and writes have been accepted since reset.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   mem_ren    in   read request (at most one per cycle)
//   mem_raddr  in   [63:0] byte address of the read
//   mem_rvalid out  read data valid, one pulse per request
//   mem_rdata  out  [63:0] read data, 0 whenever mem_rvalid is 0
//   mem_err    out  misaligned-read flag, qualified by mem_rvalid
//                   (present only when LSU_MEM_ALIGN_CHECK_EN is defined)
//   mem_wen    in   write request
//   mem_waddr  in   [63:0] byte address of the write
//   mem_wdata  in   [63:0] write data, full doubleword
//   rd_count   out  [CNT_BITS-1:0] accepted reads since reset (wraps)
//   wr_count   out  [CNT_BITS-1:0] accepted writes since reset (wraps)
//
// Optional feature macro: LSU_MEM_ALIGN_CHECK_EN
//   When it is defined, reads whose address has nonzero bits [2:0] still
//   return the word, but they also raise mem_err. Writes whose address is
//   misaligned in the same way are dropped, although they are still counted.
//   When it is not defined, address bits [2:0] are ignored.
// ----------------------------------------------------------------------------
module lsu_mem_responder #(
  parameter int DEPTH_BITS   = 10,
  parameter int READ_LATENCY = 2,
  parameter int CNT_BITS     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_ren,
  input  logic [63:0]         mem_raddr,
  output logic                mem_rvalid,
  output logic [63:0]         mem_rdata,
`ifdef LSU_MEM_ALIGN_CHECK_EN
  output logic                mem_err,
`endif
  input  logic                mem_wen,
  input  logic [63:0]         mem_waddr,
  input  logic [63:0]         mem_wdata,
  output logic [CNT_BITS-1:0] rd_count,
  output logic [CNT_BITS-1:0] wr_count
);

  localparam int WORDS = 1 << DEPTH_BITS;
  // Clamp the latency so the pipeline arrays stay legal while the
  // elaboration error below reports a bad parameter value.
  localparam int LAT = (READ_LATENCY < 1) ? 1 : ((READ_LATENCY > 8) ? 8 : READ_LATENCY);
  localparam logic [CNT_BITS-1:0] CNT_ONE = 1;

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
      $error("lsu_mem_responder: READ_LATENCY=%0d outside legal range 1..8", READ_LATENCY);
    end
  endgenerate

  logic [63:0]           mem_reg [WORDS];
  logic [DEPTH_BITS-1:0] raddr_idx;
  logic [DEPTH_BITS-1:0] waddr_idx;
  logic                  wr_commit;
  logic                  rd_misalign;

  logic                  valid_reg [LAT];
  logic [63:0]           data_reg  [LAT];
  logic                  err_reg   [LAT];

  logic [CNT_BITS-1:0]   rd_count_reg;
  logic [CNT_BITS-1:0]   wr_count_reg;

  // Upper address bits simply alias modulo the array size.
  assign raddr_idx = mem_raddr[DEPTH_BITS+2:3];
  assign waddr_idx = mem_waddr[DEPTH_BITS+2:3];

`ifdef LSU_MEM_ALIGN_CHECK_EN
  logic unused_addr_bits;
  assign rd_misalign = |mem_raddr[2:0];
  assign wr_commit   = mem_wen & ~rst & (mem_waddr[2:0] == 3'b000);
  assign unused_addr_bits = ^{mem_raddr[63:DEPTH_BITS+3], mem_waddr[63:DEPTH_BITS+3]};
  assign mem_err     = err_reg[LAT-1];
`else
  logic unused_addr_bits;
  assign rd_misalign = 1'b0;
  assign wr_commit   = mem_wen & ~rst;
  assign unused_addr_bits = ^{mem_raddr[63:DEPTH_BITS+3], mem_raddr[2:0],
                              mem_waddr[63:DEPTH_BITS+3], mem_waddr[2:0],
                              err_reg[LAT-1]};
`endif

  // The storage array has no reset, so its contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem_reg[waddr_idx] <= mem_wdata;
    end
  end

  // Read pipeline. Stage 0 samples the array through a nonblocking read, so
  // it sees the contents from before any write on the same edge
  // (read-before-write). Data and err stay zero in every slot that is not
  // valid, so the output needs no qualifying mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        valid_reg[i] <= 1'b0;
        data_reg[i]  <= '0;
        err_reg[i]   <= 1'b0;
      end
    end else begin
      valid_reg[0] <= mem_ren;
      data_reg[0]  <= mem_ren ? mem_reg[raddr_idx] : 64'd0;
      err_reg[0]   <= mem_ren & rd_misalign;
      for (int i = 1; i < LAT; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        data_reg[i]  <= data_reg[i-1];
        err_reg[i]   <= err_reg[i-1];
      end
    end
  end

  assign mem_rvalid = valid_reg[LAT-1];
  assign mem_rdata  = data_reg[LAT-1];

  // A misaligned write that is dropped still counts as an accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      if (mem_ren) rd_count_reg <= rd_count_reg + CNT_ONE;
      if (mem_wen) wr_count_reg <= wr_count_reg + CNT_ONE;
    end
  end

  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_responder
//
// Directed bench for lsu_mem_responder. Each step drives one cycle of
// requests. When a read is issued, the step pushes the expected data and the
// edge on which the result is due into a scoreboard queue. After each edge,
// the step checks mem_rvalid and mem_rdata against the head of that queue.
// It also checks both counters against a bench-side count.
// ----------------------------------------------------------------------------
module tb_lsu_mem_responder;

  localparam int DEPTH_BITS   = 10;
  localparam int READ_LATENCY = 2;
  localparam int CNT_BITS     = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                mem_ren;
  logic [63:0]         mem_raddr;
  logic                mem_rvalid;
  logic [63:0]         mem_rdata;
  logic                mem_wen;
  logic [63:0]         mem_waddr;
  logic [63:0]         mem_wdata;
  logic [CNT_BITS-1:0] rd_count;
  logic [CNT_BITS-1:0] wr_count;
`ifdef LSU_MEM_ALIGN_CHECK_EN
  logic                mem_err;
`endif

  always #5 clk = ~clk;

  lsu_mem_responder #(
    .DEPTH_BITS  (DEPTH_BITS),
    .READ_LATENCY(READ_LATENCY),
    .CNT_BITS    (CNT_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
`ifdef LSU_MEM_ALIGN_CHECK_EN
    .mem_err   (mem_err),
`endif
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t                sb[$];
  int                  edge_cnt    = 0;
  int                  vectors     = 0;
  int                  miscompares = 0;
  logic [CNT_BITS-1:0] rd_exp      = '0;
  logic [CNT_BITS-1:0] wr_exp      = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, take the edge, update the model, check outputs.
  task automatic step(input logic rs,
                      input logic r, input logic [63:0] ra,
                      input logic [63:0] rd_exp_data, input logic rd_exp_err,
                      input logic w, input logic [63:0] wa, input logic [63:0] wd);
    exp_t e;
    logic exp_valid;
    rst = rs; mem_ren = r; mem_raddr = ra; mem_wen = w; mem_waddr = wa; mem_wdata = wd;
    @(posedge clk);
    edge_cnt++;
    if (rs) begin
      sb.delete();
      rd_exp = '0;
      wr_exp = '0;
    end else begin
      if (r) begin
        e.data = rd_exp_data;
        e.err  = rd_exp_err;
        e.due  = edge_cnt + READ_LATENCY - 1;
        sb.push_back(e);
        rd_exp = rd_exp + 1'b1;
      end
      if (w) wr_exp = wr_exp + 1'b1;
    end
    #1;
    exp_valid = (sb.size() > 0) && (sb[0].due == edge_cnt);
    $display("edge %0d: rst=%0b ren=%0b raddr=%h wen=%0b waddr=%h wdata=%h -> rvalid=%0b rdata=%h rd=%0d wr=%0d",
             edge_cnt, rs, r, ra, w, wa, wd, mem_rvalid, mem_rdata, rd_count, wr_count);
    check("rvalid", {63'd0, mem_rvalid}, {63'd0, exp_valid});
    if (exp_valid) begin
      check("rdata", mem_rdata, sb[0].data);
`ifdef LSU_MEM_ALIGN_CHECK_EN
      check("err", {63'd0, mem_err}, {63'd0, sb[0].err});
`endif
      void'(sb.pop_front());
    end else begin
      check("rdata_idle", mem_rdata, 64'd0);
`ifdef LSU_MEM_ALIGN_CHECK_EN
      check("err_idle", {63'd0, mem_err}, 64'd0);
`endif
    end
    check("rd_count", {32'd0, rd_count}, {32'd0, rd_exp});
    check("wr_count", {32'd0, wr_count}, {32'd0, wr_exp});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic rd(input logic [63:0] a, input logic [63:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic rd_err(input logic [63:0] a, input logic [63:0] d, input logic er);
    step(1'b0, 1'b1, a, d, er, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    rst = 1'b1; mem_ren = 1'b0; mem_raddr = '0; mem_wen = 1'b0; mem_waddr = '0; mem_wdata = '0;

    // Reset state.
    step(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);

    // Write, then read the same word one cycle later; data arrives 2 cycles on.
    wr(64'h40, 64'hDEAD_BEEF_0000_0001);
    rd(64'h40, 64'hDEAD_BEEF_0000_0001);
    idle();
    idle();
    check("t1_rd_count", {32'd0, rd_count}, 64'd1);
    check("t1_wr_count", {32'd0, wr_count}, 64'd1);

    // Back-to-back reads return in order, one per cycle.
    wr(64'h00, 64'd1);
    wr(64'h08, 64'd2);
    wr(64'h10, 64'd3);
    wr(64'h18, 64'd4);
    rd(64'h00, 64'd1);
    rd(64'h08, 64'd2);
    rd(64'h10, 64'd3);
    rd(64'h18, 64'd4);
    idle();
    idle();
    idle();

    // Same-cycle read and write to one word: read gets the old value.
    wr(64'h80, 64'h11);
    step(1'b0, 1'b1, 64'h80, 64'h11, 1'b0, 1'b1, 64'h80, 64'h22);
    rd(64'h80, 64'h22);
    idle();
    idle();

    // Address aliasing modulo the array size.
    wr(64'd8 << DEPTH_BITS, 64'h55);
    rd(64'h0, 64'h55);
    rd((64'h1 << 40) | 64'h8, 64'd2);
    idle();
    idle();

`ifdef LSU_MEM_ALIGN_CHECK_EN
    rd_err(64'h43, 64'hDEAD_BEEF_0000_0001, 1'b1);
    wr(64'h45, 64'h99);
    rd_err(64'h40, 64'hDEAD_BEEF_0000_0001, 1'b0);
    idle();
    idle();
`else
    // Low address bits are ignored.
    rd_err(64'h43, 64'hDEAD_BEEF_0000_0001, 1'b0);
    wr(64'h45, 64'h99);
    rd(64'h40, 64'h99);
    idle();
    idle();
`endif

    // Reset mid-flight: the read is dropped, and requests during reset are
    // ignored (the write to 0x100 must not land).
    wr(64'h100, 64'h1234);
    rd(64'h100, 64'h1234);
    step(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b1, 1'b1, 64'h100, 64'd0, 1'b0, 1'b1, 64'h100, 64'hBAD);
    idle();
    idle();
    idle();
    check("rst_rd_count", {32'd0, rd_count}, 64'd0);
    check("rst_wr_count", {32'd0, wr_count}, 64'd0);
    rd(64'h100, 64'h1234);
    rd(64'h80, 64'h22);
    idle();
    idle();
    idle();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_responder.md
Name: lsu_mem_responder

Overview:
- Data-memory responder for the load/store unit's memory port; it is the target end of the mem_ren/mem_raddr/mem_rvalid/mem_rdata read channel and the mem_wen/mem_waddr/mem_wdata write channel.
- Holds a doubleword-addressed storage array, answers reads through a fixed-latency pipeline and commits writes in one cycle.
- Keeps request counters for bench and performance visibility.
- Used in LSU testbenches and as the core's simple data memory.

Parameters:
- DEPTH_BITS, 10, log2 of the number of 64-bit words (1024 words by default).
- READ_LATENCY, 2, cycles from mem_ren sampled high to mem_rvalid high; legal range 1..8.
- CNT_BITS, 32, width of the read and write request counters.

Ports:
- clk  input  1  clock; all logic acts on the rising edge.
- rst  input  1  synchronous active-high reset.
- mem_ren  input  1  read request, one per cycle maximum.
- mem_raddr  input  64  byte address of the read.
- mem_rvalid  output  1  read data valid, one-cycle pulse per request.
- mem_rdata  output  64  read data.
- mem_wen  input  1  write request.
- mem_waddr  input  64  byte address of the write.
- mem_wdata  input  64  write data, full doubleword.
- rd_count  output  CNT_BITS  number of accepted reads since reset.
- wr_count  output  CNT_BITS  number of accepted writes since reset.

Behaviour:
- Address decode: word index = addr[DEPTH_BITS+2:3]. Bits [2:0] are ignored; the optional feature changes this. Bits above DEPTH_BITS+2 are ignored, so accesses alias modulo the array size.
- Ready behaviour: always ready, no backpressure. Every cycle with mem_ren=1 is an accepted read and every cycle with mem_wen=1 is an accepted write.
- Write: on the edge where mem_wen=1, mem[index] <= mem_wdata. It is visible to reads sampled on the next edge onward.
- Read: on the edge where mem_ren=1, mem[index] is captured into stage 1 of a READ_LATENCY-deep valid/data shift pipeline.
  - Data is taken from array contents before any write on the same edge (read-before-write). A same-cycle read and write to the same word therefore returns the old value.
  - mem_rvalid and mem_rdata are driven from the last stage. A request on edge N produces mem_rvalid=1 in the cycle after edge N+READ_LATENCY-1, i.e. READ_LATENCY cycles after the request cycle.
  - Back-to-back reads are fully pipelined and return in order, one per cycle.
- mem_rdata while mem_rvalid=0 is 0: stage data is cleared whenever its valid bit is 0.
- Counters:
  - rd_count increments by 1 per accepted read; wr_count increments by 1 per accepted write; both may increment on the same edge.
  - Both wrap from all-ones to 0 with no saturation.
- Reset:
  - mem_rvalid=0, mem_rdata=0, rd_count=0, wr_count=0.
  - All pipeline stages are invalidated, so in-flight reads are dropped and no rvalid is produced for requests made before or during reset.
  - Requests presented while rst=1 are ignored: no array write, no counter update.
  - Array contents are not reset and are preserved across rst.
- Illegal READ_LATENCY (outside 1..8) is rejected at elaboration with $error.

Optional Feature:
- Macro LSU_MEM_ALIGN_CHECK_EN.
- When defined:
  - Adds output port mem_err (1 bit, reset 0), pipelined alongside mem_rvalid.
  - A read with raddr[2:0] != 0 still returns mem[index] but asserts mem_err together with its mem_rvalid.
  - A write with waddr[2:0] != 0 is dropped: array unchanged, wr_count still increments.
  - mem_err is 0 whenever mem_rvalid=0.
- When not defined: no mem_err port; low address bits are silently ignored for reads and writes.

Test Plan:
- Reset, then write 0xDEAD_BEEF_0000_0001 to 0x40 and read 0x40 one cycle later -> mem_rvalid exactly READ_LATENCY (2) cycles after the read request with mem_rdata=0xDEAD_BEEF_0000_0001; rd_count=1, wr_count=1.
- Fill words 0x00, 0x08, 0x10, 0x18 with 1..4, then issue 4 consecutive reads -> 4 consecutive rvalid cycles returning 1, 2, 3, 4 in order; mem_rdata=0 on the cycles before and after.
- Same-cycle read and write to 0x80 (old value 0x11, new 0x22) -> read returns 0x11; a following read returns 0x22.
- Alias: write 0x55 to address 8<<DEPTH_BITS (0x2000 with defaults), read 0x0 -> 0x55.
- Reset mid-flight: issue a read, assert rst one cycle later -> no mem_rvalid ever; counters are 0; data written before reset is still readable after it.
- With LSU_MEM_ALIGN_CHECK_EN, read 0x43 -> rvalid with mem_err=1 and the data of word 0x40; write 0x99 to 0x45 -> word 0x40 unchanged, wr_count incremented.
